// File: rtl/code_entry_ctrl.sv
// Two-digit code entry controller: synchronises a pushbutton, collects two BCD digits,
// compares them against a fixed code and drives HEX/unlock/fail/lockout indicators.
module code_entry_ctrl #(
  parameter int DIGIT_HI    = 2,
  parameter int DIGIT_LO    = 3,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_n,
  input  logic [3:0] digit,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       unlock,
  output logic       fail,
  output logic       err,
  output logic       locked,
  output logic [1:0] fail_cnt
);

  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [2:0] {IDLE, GOT_HI, CHECK, OPEN, LOCKOUT} state_t;

  state_t          state_q, state_d;
  logic            s1_q, s2_q, s3_q;
  logic [3:0]      hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [1:0]      fail_cnt_q, fail_cnt_d;
  logic [6:0]      hex1_q, hex1_d, hex0_q, hex0_d;
  logic            unlock_q, unlock_d, fail_q, fail_d;
  logic            err_q, err_d, locked_q, locked_d;

  logic            press, digit_ok, code_ok, lockout_hit, lock_done;
  logic [1:0]      fail_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // One press per falling edge: s3 still high while s2 has already seen the low level.
  assign press       = s3_q & ~s2_q;
  assign digit_ok    = (digit <= 4'd9);
  assign code_ok     = (hi_q == 4'(DIGIT_HI)) && (lo_q == 4'(DIGIT_LO));
  assign fail_next   = fail_cnt_q + 2'd1;
  assign lockout_hit = (fail_next == 2'(MAX_FAIL));
  assign lock_done   = (lock_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      s3_q       <= 1'b1;
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      lock_cnt_q <= '0;
      fail_cnt_q <= '0;
      hex1_q     <= SEG_BLANK;
      hex0_q     <= SEG_BLANK;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      s1_q       <= enter_n;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      lock_cnt_q <= lock_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      hex1_q     <= hex1_d;
      hex0_q     <= hex0_d;
      unlock_q   <= unlock_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    lock_cnt_d = lock_cnt_q;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      IDLE: if (press && digit_ok) begin
        hi_d    = digit;
        state_d = GOT_HI;
      end
      GOT_HI: if (press && digit_ok) begin
        lo_d    = digit;
        state_d = CHECK;
      end
      CHECK: begin
        if (code_ok) begin
          state_d    = OPEN;
          fail_cnt_d = '0;
        end else begin
          fail_cnt_d = fail_next;
          if (lockout_hit) begin
            state_d    = LOCKOUT;
            lock_cnt_d = CW'(LOCK_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      OPEN: if (press) state_d = IDLE;
      LOCKOUT: begin
        if (lock_done) begin
          state_d    = IDLE;
          fail_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded from the transition being taken, so they line up with state_q.
  always_comb begin
    hex1_d   = hex1_q;
    hex0_d   = hex0_q;
    unlock_d = (state_d == OPEN);
    locked_d = (state_d == LOCKOUT);
    fail_d   = (state_q == CHECK) && !code_ok;
    err_d    = press && !digit_ok && ((state_q == IDLE) || (state_q == GOT_HI));
    case (state_q)
      IDLE:   if (press && digit_ok) hex1_d = seg7(digit);
      GOT_HI: if (press && digit_ok) hex0_d = seg7(digit);
      CHECK: if (!code_ok) begin
        hex1_d = lockout_hit ? SEG_DASH : SEG_BLANK;
        hex0_d = lockout_hit ? SEG_DASH : SEG_BLANK;
      end
      OPEN: if (press) begin
        hex1_d = SEG_BLANK;
        hex0_d = SEG_BLANK;
      end
      LOCKOUT: if (lock_done) begin
        hex1_d = SEG_BLANK;
        hex0_d = SEG_BLANK;
      end
      default: begin
        hex1_d = SEG_BLANK;
        hex0_d = SEG_BLANK;
      end
    endcase
  end

  assign hex1     = hex1_q;
  assign hex0     = hex0_q;
  assign unlock   = unlock_q;
  assign fail     = fail_q;
  assign err      = err_q;
  assign locked   = locked_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Bench for code_entry_ctrl: directed scenarios with literal expectations, then random presses,
// every cycle compared against an event-level model of the code lock.
module tb_code_entry_ctrl;

  localparam int HI = 2, LO = 3, MAXF = 3, LOCKC = 8;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  logic       clk, reset, enter_n;
  logic [3:0] digit;
  logic [6:0] hex1, hex0;
  logic       unlock, fail, err, locked;
  logic [1:0] fail_cnt;

  int errors = 0;
  int checks = 0;
  logic armed = 1'b0;

  code_entry_ctrl #(.DIGIT_HI(HI), .DIGIT_LO(LO), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKC)) dut (
    .clk(clk), .reset(reset), .enter_n(enter_n), .digit(digit),
    .hex1(hex1), .hex0(hex0), .unlock(unlock), .fail(fail), .err(err),
    .locked(locked), .fail_cnt(fail_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0] exp_q[$];          // digits collected for the current attempt
  logic [2:0] hist;              // button samples, bit0 = most recent edge
  logic       m_open, m_check;
  int         m_lock_left, m_fail_cnt;
  logic [6:0] e_hex1, e_hex0;
  logic       e_fail, e_err;

  task automatic model_reset();
    hist = 3'b111;
    exp_q.delete();
    m_open = 0; m_check = 0; m_lock_left = 0; m_fail_cnt = 0;
    e_hex1 = BLANK; e_hex0 = BLANK; e_fail = 0; e_err = 0;
  endtask

  task automatic model_step();
    logic pressed;
    if (reset) begin
      model_reset();
    end else begin
      pressed = !hist[1] && hist[2];
      hist = {hist[1:0], enter_n};
      e_fail = 0;
      e_err  = 0;
      if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0) begin
          m_fail_cnt = 0; e_hex1 = BLANK; e_hex0 = BLANK;
        end
      end else if (m_check) begin
        m_check = 0;
        if (exp_q[0] == 4'(HI) && exp_q[1] == 4'(LO)) begin
          m_open = 1; m_fail_cnt = 0;
        end else begin
          e_fail = 1;
          m_fail_cnt++;
          if (m_fail_cnt == MAXF) begin
            m_lock_left = LOCKC; e_hex1 = DASH; e_hex0 = DASH;
          end else begin
            e_hex1 = BLANK; e_hex0 = BLANK;
          end
        end
        exp_q.delete();
      end else if (m_open) begin
        if (pressed) begin
          m_open = 0; e_hex1 = BLANK; e_hex0 = BLANK;
        end
      end else if (pressed) begin
        if (digit > 4'd9) e_err = 1;
        else begin
          exp_q.push_back(digit);
          if (exp_q.size() == 1) e_hex1 = seg_tab[digit];
          else begin
            e_hex0 = seg_tab[digit];
            m_check = 1;
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("m_hex1", 32'(hex1), 32'(e_hex1));
        chk("m_hex0", 32'(hex0), 32'(e_hex0));
        chk("m_unlock", 32'(unlock), 32'(m_open));
        chk("m_fail", 32'(fail), 32'(e_fail));
        chk("m_err", 32'(err), 32'(e_err));
        chk("m_locked", 32'(locked), 32'(m_lock_left > 0));
        chk("m_fail_cnt", 32'(fail_cnt), 32'(m_fail_cnt));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_digit(input int d, input int hold, input int gap);
    digit   = 4'(d);
    enter_n = 1'b0;
    cyc(hold);
    enter_n = 1'b1;
    cyc(gap);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_fail, n_err, n_lock;
    logic [6:0] lock_hex;
    reset = 1'b1; enter_n = 1'b1; digit = 4'd0;
    cyc(2);
    reset = 1'b0;
    armed = 1'b1;
    cyc(1);
    chk("rst_hex1", 32'(hex1), 32'(BLANK));
    chk("rst_hex0", 32'(hex0), 32'(BLANK));
    chk("rst_flags", 32'({unlock, fail, err, locked}), 32'(0));
    chk("rst_fail_cnt", 32'(fail_cnt), 32'(0));

    // correct code
    press_digit(2, 2, 4);
    chk("ok_hex1", 32'(hex1), 32'(7'b0100100));
    chk("ok_hex0_blank", 32'(hex0), 32'(BLANK));
    press_digit(3, 2, 4);
    chk("ok_hex0", 32'(hex0), 32'(7'b0110000));
    chk("ok_unlock", 32'(unlock), 32'(1));
    chk("ok_fail_cnt", 32'(fail_cnt), 32'(0));
    press_digit(5, 2, 4);
    chk("relock_unlock", 32'(unlock), 32'(0));
    chk("relock_hex", 32'({hex1, hex0}), 32'({BLANK, BLANK}));

    // single mismatch, then the right code
    press_digit(2, 2, 4);
    digit = 4'd5; enter_n = 1'b0; n_fail = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) enter_n = 1'b1;
      if (fail) n_fail++;
    end
    chk("mis_fail_len", 32'(n_fail), 32'(1));
    chk("mis_fail_cnt", 32'(fail_cnt), 32'(1));
    chk("mis_hex", 32'({hex1, hex0}), 32'({BLANK, BLANK}));
    press_digit(2, 2, 4);
    press_digit(3, 2, 4);
    chk("mis_then_ok_unlock", 32'(unlock), 32'(1));
    chk("mis_then_ok_cnt", 32'(fail_cnt), 32'(0));
    press_digit(0, 2, 4);

    // lockout after three wrong codes, presses hammered during lockout
    for (int k = 0; k < 2; k++) begin
      press_digit(1, 2, 4);
      press_digit(1, 2, 4);
    end
    chk("pre_lock_cnt", 32'(fail_cnt), 32'(2));
    press_digit(1, 2, 4);
    digit = 4'd1; enter_n = 1'b0; n_lock = 0; lock_hex = BLANK;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (locked) begin
        n_lock++;
        lock_hex = hex1 & hex0;
        if (n_lock == 1) chk("lock_fail_cnt", 32'(fail_cnt), 32'(3));
      end
      if (i == 0) enter_n = 1'b1;
      else if (i >= 2 && i <= 9) begin
        digit   = 4'd2;
        enter_n = i[0];
      end
    end
    chk("lock_len", 32'(n_lock), 32'(LOCKC));
    chk("lock_hex", 32'(lock_hex), 32'(DASH));
    chk("unlock_after_lock", 32'({locked, fail_cnt}), 32'(0));
    chk("blank_after_lock", 32'({hex1, hex0}), 32'({BLANK, BLANK}));

    // invalid digit
    digit = 4'd12; enter_n = 1'b0; n_err = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) enter_n = 1'b1;
      if (err) n_err++;
    end
    chk("inv_err_len", 32'(n_err), 32'(1));
    chk("inv_hex1", 32'(hex1), 32'(BLANK));
    press_digit(7, 2, 4);
    chk("inv_then_hex1", 32'(hex1), 32'(7'b1111000));
    press_digit(9, 2, 4);
    chk("inv_then_fail_cnt", 32'(fail_cnt), 32'(1));

    // held button: exact latency and single capture
    digit = 4'd2; enter_n = 1'b0;
    @(negedge clk); chk("held_e0", 32'(hex1), 32'(BLANK));
    @(negedge clk); chk("held_e1", 32'(hex1), 32'(BLANK));
    @(negedge clk); chk("held_e2", 32'(hex1), 32'(7'b0100100));
    cyc(17);
    enter_n = 1'b1;
    cyc(4);
    chk("held_one_capture", 32'(hex0), 32'(BLANK));

    // reset mid-entry
    pulse_reset();
    chk("midrst_hex1", 32'(hex1), 32'(BLANK));
    chk("midrst_flags", 32'({unlock, fail, err, locked, fail_cnt}), 32'(0));
    cyc(5);
    chk("midrst_quiet", 32'({hex1, hex0, err}), 32'({BLANK, BLANK, 1'b0}));

    // random presses
    for (int n = 0; n < 300; n++) begin
      int r, d;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pulse_reset();
        continue;
      end
      if (r < 50) d = (exp_q.size() == 0) ? HI : LO;
      else d = $urandom_range(0, 15);
      press_digit(d, $urandom_range(1, 4), $urandom_range(1, 5));
    end
    cyc(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
